// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder: FSM states,
// phase codes and the Gray-code step classifier.
package quad_pkg;

  typedef enum logic {ST_INIT, ST_TRACK} state_e;

  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_e;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Successor of a phase code in the forward sequence 00->01->11->10->00.
  function automatic logic [1:0] next_fwd(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  function automatic step_e step_dir(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur)
      return STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      return STEP_ILLEGAL;
    else if (cur == next_fwd(prev))
      return STEP_FWD;
    else
      return STEP_REV;
  endfunction

endpackage

// File: rtl/phase_filter.sv
// Synchroniser plus debounce for one asynchronous encoder phase; the output
// level only follows the pin after DEBOUNCE consecutive differing samples.
module phase_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3
) (
  input  logic clock,
  input  logic clear_b,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CW-1:0]          deb_cnt_p1;
  logic                   level_p1;
  logic                   synced;

  assign synced = sync_p0[SYNC_STAGES-1];
  assign dout   = level_p1;

  // Stage p0: metastability chain.
  always_ff @(posedge clock) begin
    if (clear_b)
      sync_p0 <= '0;
    else
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
  end

  // Stage p1: a sample equal to the held level restarts the run length.
  always_ff @(posedge clock) begin
    if (clear_b) begin
      deb_cnt_p1 <= '0;
      level_p1   <= 1'b0;
    end else if (synced == level_p1) begin
      deb_cnt_p1 <= '0;
    end else if (deb_cnt_p1 == CW'(DEBOUNCE - 1)) begin
      level_p1   <= synced;
      deb_cnt_p1 <= '0;
    end else begin
      deb_cnt_p1 <= deb_cnt_p1 + CW'(1);
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filtered phases feed a two-state tracker that emits
// registered up/down/err strobes and maintains a wrapping position count.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             enable,
  input  logic             phase_a,
  input  logic             phase_b,
  output logic             up,
  output logic             down,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  // INIT holds until both filters have had time to reflect the pins after
  // their own reset, so a step interrupted by reset never produces a strobe.
  localparam int INIT_CYC = SYNC_STAGES + DEBOUNCE + 1;
  localparam int IW       = $clog2(INIT_CYC);

  logic             a_filt, b_filt;
  logic [1:0]       s;
  state_e           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [IW-1:0]    init_q, init_d;
  step_e            dir;
  logic             up_d, down_d, err_d, wrap_d;
  logic [WIDTH-1:0] count_d;

  phase_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_filt_a (
    .clock(clock), .clear_b(clear_b), .din(phase_a), .dout(a_filt)
  );

  phase_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_filt_b (
    .clock(clock), .clear_b(clear_b), .din(phase_b), .dout(b_filt)
  );

  assign s = {a_filt, b_filt};

  always_comb begin
    state_d = state_q;
    prev_d  = s;
    init_d  = init_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    count_d = count;
    dir     = step_dir(prev_q, s);
    case (state_q)
      ST_INIT: begin
        if (init_q == IW'(INIT_CYC - 1))
          state_d = ST_TRACK;
        else
          init_d = init_q + IW'(1);
      end
      ST_TRACK: begin
        // prev keeps following s while disabled, so re-enabling sees no stale step.
        case (dir)
          STEP_FWD: if (enable) begin
            up_d    = 1'b1;
            count_d = count + WIDTH'(1);
            wrap_d  = (count == '1);
          end
          STEP_REV: if (enable) begin
            down_d  = 1'b1;
            count_d = count - WIDTH'(1);
            wrap_d  = (count == '0);
          end
          STEP_ILLEGAL: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Stage p2: strobes and count are registered together.
  always_ff @(posedge clock) begin
    if (clear_b) begin
      state_q <= ST_INIT;
      prev_q  <= PH_00;
      init_q  <= '0;
      up      <= 1'b0;
      down    <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      init_q  <= init_d;
      up      <= up_d;
      down    <= down_d;
      err     <= err_d;
      wrap    <= wrap_d;
      count   <= count_d;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: each driven step queues its
// expected strobe, which the negedge monitor pops when the DUT fires.
module tb_quad_step_decoder;

  logic       clock = 1'b0;
  logic       clear_b = 1'b1;
  logic       enable = 1'b1;
  logic       phase_a = 1'b0;
  logic       phase_b = 1'b0;
  logic       up, down, wrap, err;
  logic [3:0] count;

  typedef struct {
    logic [2:0] kind;   // {up, down, err}
    logic       wrap;
    logic [3:0] cnt;
    int         t0;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         pidx = 0;
  logic [3:0] m_count = 4'd0;

  quad_step_decoder #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(3)) dut (
    .clock(clock), .clear_b(clear_b), .enable(enable),
    .phase_a(phase_a), .phase_b(phase_b),
    .up(up), .down(down), .count(count), .wrap(wrap), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!clear_b && (up || down || err || wrap)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", 32'({up, down, err, wrap}), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq({e.tag, "_kind"},  32'({up, down, err}), 32'(e.kind));
        check_eq({e.tag, "_wrap"},  32'(wrap), 32'(e.wrap));
        check_eq({e.tag, "_count"}, 32'(count), 32'(e.cnt));
        check_eq({e.tag, "_lat"},   32'(cyc - e.t0), 32'd6);
      end
    end
  end

  // dir: 1 forward, -1 reverse, 2 illegal double-bit jump
  task automatic move(input int dir, input string tag);
    exp_t e;
    @(posedge clock); #1;
    e.t0 = cyc;
    e.tag = tag;
    e.wrap = 1'b0;
    if (dir == 2) begin
      pidx = (pidx + 2) % 4;
      e.kind = 3'b001;
    end else if (dir == 1) begin
      pidx = (pidx + 1) % 4;
      e.kind = 3'b100;
      e.wrap = (m_count == 4'hF);
      if (enable) m_count = m_count + 4'd1;
    end else begin
      pidx = (pidx + 3) % 4;
      e.kind = 3'b010;
      e.wrap = (m_count == 4'h0);
      if (enable) m_count = m_count - 4'd1;
    end
    e.cnt = m_count;
    if (enable || dir == 2) sb.push_back(e);
    {phase_a, phase_b} = seq[pidx];
    repeat (9) @(posedge clock);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    check_eq({tag, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_strobes", 32'({up, down, wrap, err}), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    @(posedge clock); #1;
    clear_b = 1'b0;
    repeat (10) @(posedge clock);

    // 1: sixteen forward steps, wrap on 15->0
    for (int i = 0; i < 16; i++) move(1, $sformatf("fwd%0d", i));
    drain("t1");
    @(negedge clock);
    check_eq("t1_count", 32'(count), 32'(m_count));

    // 2: reverse from 0 wraps to 15
    move(-1, "rev_wrap");
    drain("t2");

    // 3: back to 00, then a 2-cycle glitch on phase_a must be ignored
    move(1, "fwd_to00");
    drain("t3a");
    @(posedge clock); #1;
    phase_a = 1'b1;
    repeat (2) @(posedge clock); #1;
    phase_a = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    check_eq("glitch_count", 32'(count), 32'(m_count));
    check_eq("glitch_strobes", 32'({up, down, err}), 32'd0);

    // 4: illegal 01->10 jump, then legal 10->00
    move(1, "fwd_to01");
    move(2, "illegal");
    move(1, "after_err");
    drain("t4");

    // 5: three steps while disabled, one after re-enable
    enable = 1'b0;
    for (int i = 0; i < 3; i++) move(1, "disabled");
    @(negedge clock);
    check_eq("dis_count_hold", 32'(count), 32'(m_count));
    enable = 1'b1;
    move(1, "reenable");
    drain("t5");
    @(negedge clock);
    check_eq("t5_count", 32'(count), 32'd3);

    // 6: bring count to 7, reset in the middle of an edge's debounce
    for (int i = 0; i < 4; i++) move(1, "to7");
    drain("t6a");
    @(negedge clock);
    check_eq("pre_rst_count", 32'(count), 32'd7);
    @(posedge clock); #1;
    pidx = 1;
    {phase_a, phase_b} = seq[pidx];
    repeat (3) @(posedge clock); #1;
    clear_b = 1'b1;
    @(posedge clock); #1;
    clear_b = 1'b0;
    m_count = 4'd0;
    @(negedge clock);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    repeat (12) @(posedge clock);
    @(negedge clock);
    check_eq("post_rst_count", 32'(count), 32'd0);
    move(1, "post_rst_step");
    drain("t6b");
    @(negedge clock);
    check_eq("final_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
